// File: rtl/regfile_sb_if.sv
// Bus interface for regfile_sb: decode/writeback side (master) and register file (slave).
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) ();
    logic              clr_req;
    logic              init_done;
    logic              regwrite;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rsv;
    logic [ADDR_W-1:0] rsv_addr;
    logic              busy1;
    logic              busy2;

    modport master (
        output clr_req, regwrite, wa, wd, ra1, ra2, rsv, rsv_addr,
        input  init_done, rd1, rd2, busy1, busy2
    );

    modport slave (
        input  clr_req, regwrite, wa, wd, ra1, ra2, rsv, rsv_addr,
        output init_done, rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with registered write-first reads, a per-entry
// busy scoreboard and a sequential clear engine (INIT) that zeroes the array.
// Optional build macro REGFILE_SB_ZERO_R0_EN hardwires entry 0 to zero and
// makes it never busy.
module regfile_sb #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              run_c;
    logic              we_c;
    logic              rsv_c;
    logic [DEPTH-1:0]  busy_nxt_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // Effective write/reserve qualifiers, post-update busy vector and bypassed read data.
    always_comb begin
        run_c = (state == S_RUN) && !bus.clr_req;
`ifdef REGFILE_SB_ZERO_R0_EN
        we_c  = run_c && bus.regwrite && (bus.wa != '0);
        rsv_c = run_c && bus.rsv && (bus.rsv_addr != '0);
`else
        we_c  = run_c && bus.regwrite;
        rsv_c = run_c && bus.rsv;
`endif
        busy_nxt_c = busy;
        if (we_c) begin
            busy_nxt_c[bus.wa] = 1'b0;
        end
        // A new reservation outranks a same-cycle release of the same entry.
        if (rsv_c) begin
            busy_nxt_c[bus.rsv_addr] = 1'b1;
        end
        rd1_c = (we_c && (bus.wa == bus.ra1)) ? bus.wd : mem[bus.ra1];
        rd2_c = (we_c && (bus.wa == bus.ra2)) ? bus.wd : mem[bus.ra2];
    end

    // Array storage: cleared entry by entry in INIT, written by the write port in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[cnt] <= '0;
            end else if (we_c) begin
                mem[bus.wa] <= bus.wd;
            end
        end
    end

    // Clear-engine FSM, scoreboard and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT;
            cnt           <= '0;
            busy          <= '0;
            bus.init_done <= 1'b0;
            bus.rd1       <= '0;
            bus.rd2       <= '0;
            bus.busy1     <= 1'b0;
            bus.busy2     <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    busy[cnt] <= 1'b0;
                    cnt       <= cnt + ADDR_W'(1);
                    bus.rd1   <= '0;
                    bus.rd2   <= '0;
                    bus.busy1 <= 1'b0;
                    bus.busy2 <= 1'b0;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state         <= S_RUN;
                        bus.init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    busy      <= busy_nxt_c;
                    bus.rd1   <= rd1_c;
                    bus.rd2   <= rd2_c;
                    bus.busy1 <= busy_nxt_c[bus.ra1];
                    bus.busy2 <= busy_nxt_c[bus.ra2];
                    if (bus.clr_req) begin
                        state         <= S_INIT;
                        cnt           <= '0;
                        bus.init_done <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: expected read results are queued when the
// read is driven and compared one edge later when the registered outputs appear.
module tb_regfile_sb;
    logic clk;
    logic rst;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_sb #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_rd(input string tag, input logic [15:0] r1, input logic [15:0] r2,
                             input logic b1, input logic b2);
        exp_t e;
        e.tag = tag;
        e.rd1 = r1;
        e.rd2 = r2;
        e.b1  = b1;
        e.b2  = b2;
        q.push_back(e);
    endtask

    // One clock edge; outputs sampled 1 time unit later and checked against the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.tag, "_rd1"},   32'(bus.rd1),   32'(e.rd1));
            chk({e.tag, "_rd2"},   32'(bus.rd2),   32'(e.rd2));
            chk({e.tag, "_busy1"}, 32'(bus.busy1), 32'(e.b1));
            chk({e.tag, "_busy2"}, 32'(bus.busy2), 32'(e.b2));
        end
    endtask

    task automatic idle();
        bus.regwrite = 1'b0;
        bus.rsv      = 1'b0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] ra1, input logic [3:0] ra2);
        bus.regwrite = we;
        bus.wa       = wa;
        bus.wd       = wd;
        bus.ra1      = ra1;
        bus.ra2      = ra2;
    endtask

    // Sixteen INIT edges: init_done low after the first fifteen, high after the sixteenth.
    task automatic wait_init(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("%s_init_done_%0d", tag, i), 32'(bus.init_done), (i == 16) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        bus.rsv_addr = 4'd0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) tick();
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_rd1", 32'(bus.rd1), 32'd0);
        chk("rst_busy2", 32'(bus.busy2), 32'd0);

        // Release reset; a write and reservation offered during INIT must be ignored
        rst = 1'b0;
        drive(1'b1, 4'd2, 16'h1234, 4'd0, 4'd0);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd2;
        wait_init("init");
        idle();

        // Every entry reads zero and not busy
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 16'h0000, 4'(i), 4'(15 - i));
            expect_rd($sformatf("zero_%0d", i), 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
        end

        // Plain write then read on both ports
        drive(1'b1, 4'd5, 16'h00A5, 4'd1, 4'd1);
        expect_rd("wr5", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd5);
        expect_rd("rd5", 16'h00A5, 16'h00A5, 1'b0, 1'b0);
        tick();

        // Write-first bypass
        drive(1'b1, 4'd7, 16'h1111, 4'd1, 4'd1);
        expect_rd("wr7a", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd7, 16'h2222, 4'd7, 4'd5);
        expect_rd("byp7", 16'h2222, 16'h00A5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd7, 4'd7);
        expect_rd("rd7", 16'h2222, 16'h2222, 1'b0, 1'b0);
        tick();

        // Scoreboard: reserve, release by write, same-cycle reserve+write
        drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd3);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd3;
        expect_rd("rsv3", 16'h0000, 16'h0000, 1'b1, 1'b1);
        tick();
        bus.rsv = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd3);
        expect_rd("busy3", 16'h00A5, 16'h0000, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'd3, 16'h0033, 4'd5, 4'd3);
        expect_rd("rel3", 16'h00A5, 16'h0033, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd3);
        expect_rd("free3", 16'h00A5, 16'h0033, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd3, 16'h3333, 4'd5, 4'd3);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd3;
        expect_rd("rsvwr3", 16'h00A5, 16'h3333, 1'b0, 1'b1);
        tick();
        bus.rsv = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd3);
        expect_rd("still3", 16'h00A5, 16'h3333, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'd3, 16'h4444, 4'd4, 4'd3);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd4;
        expect_rd("split", 16'h0000, 16'h4444, 1'b1, 1'b0);
        tick();
        bus.rsv = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 4'd4, 4'd3);
        expect_rd("split2", 16'h0000, 16'h4444, 1'b1, 1'b0);
        tick();

        // Clear mid-operation; write and reservation in the clr_req cycle are dropped
        drive(1'b1, 4'd9, 16'hBEEF, 4'd1, 4'd1);
        expect_rd("wr9", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd9, 4'd9);
        expect_rd("rd9", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd9, 16'h1234, 4'd9, 4'd3);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd10;
        bus.clr_req = 1'b1;
        tick();
        chk("clr_init_done", 32'(bus.init_done), 32'd0);
        idle();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 4'd0, 16'h0000, 4'd9, 4'd3);
            expect_rd($sformatf("clr_%0d", i), 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            chk($sformatf("clr_init_done_%0d", i), 32'(bus.init_done), (i == 16) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 4'd0, 16'h0000, 4'd9, 4'd3);
        expect_rd("post_clr", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd10, 4'd4);
        expect_rd("post_clr2", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();

        // Reset during clear cycle 8 restarts a full 16-cycle INIT
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_init_done", 32'(bus.init_done), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init("restart");

        // Entry 0 behaviour depends on the build option
        drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
`ifdef REGFILE_SB_ZERO_R0_EN
        expect_rd("r0_byp", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd0;
        expect_rd("r0_rsv", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        bus.rsv = 1'b0;
        expect_rd("r0_after", 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
`else
        expect_rd("r0_byp", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        bus.rsv = 1'b1;
        bus.rsv_addr = 4'd0;
        expect_rd("r0_rsv", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        tick();
        bus.rsv = 1'b0;
        expect_rd("r0_after", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        tick();
`endif

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's 16x16 two-read/one-write register file.
- Adds:
  - registered reads with write-first bypass;
  - a per-entry busy scoreboard for reserve/release of pending results;
  - a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode (read addresses, reservations) and writeback (write port) in the datapath.

Parameters:
- DATA_W, 16, width of each register and of wd/rd1/rd2.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- clr_req  input  1  request full array clear; honoured only in RUN.
- init_done  output  1  high when the array is usable (state RUN).
- regwrite  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  registered read data, port 1.
- rd2  output  DATA_W  registered read data, port 2.
- rsv  input  1  reserve an entry (mark busy).
- rsv_addr  input  ADDR_W  entry to reserve.
- busy1  output  1  registered busy flag of entry ra1.
- busy2  output  1  registered busy flag of entry ra2.

Behaviour:
- Clocking and reset:
  - Single clock domain. rst is synchronous, active-high, and has priority over every other input.
  - While rst is high, at each edge: rd1=rd2=0, busy1=busy2=0, init_done=0, all busy bits=0, clear counter=0, state=INIT.
  - Array contents are not reset directly; the clear engine zeroes them.
- States and transitions:
  - INIT:
    - Each cycle writes 0 to entry cnt and clears busy[cnt]; cnt increments.
    - When cnt==DEPTH-1 is written, state goes to RUN and cnt returns to 0.
    - Takes exactly DEPTH cycles after rst falls. init_done rises on the edge ending the last clear cycle.
  - RUN:
    - init_done=1.
    - clr_req=1 at an edge moves the state to INIT and drops init_done on that edge. Any write/rsv presented in that same cycle is ignored.
  - rst asserted mid-INIT restarts INIT from cnt=0.
- Behaviour during INIT:
  - regwrite and rsv are ignored.
  - rd1/rd2/busy1/busy2 register 0.
- Writes (RUN only): regwrite=1 stores wd into entry wa at the edge and clears busy[wa].
- Reads:
  - Read latency is 1 cycle: rdN at edge k+1 reflects raN sampled at edge k.
  - Bypass (write-first): if regwrite=1 and wa==raN in the same cycle, rdN registers wd, not the old contents.
  - Both ports may read the same address; both return identical data.
- Scoreboard:
  - rsv=1 in RUN sets busy[rsv_addr].
  - Simultaneous rsv and regwrite to the same address: the set wins, so busy stays 1 (new producer outstanding).
  - Simultaneous rsv and regwrite to different addresses: both take effect.
- busyN:
  - Registered with the same 1-cycle latency as rdN.
  - busyN reflects the post-update flag, including the same-cycle write clear and reservation set, so it is consistent with the bypassed data.
- Width and addressing: all addresses are in range by construction, so there is no wrap or overflow. cnt is ADDR_W bits and wraps to 0 when leaving INIT.

Optional Feature:
- Macro REGFILE_SB_ZERO_R0_EN.
- Defined:
  - Entry 0 is hardwired to zero: writes to wa=0 are discarded, including the bypass path, so rdN=0 whenever raN=0.
  - rsv to address 0 is ignored, and busy[0] is always 0.
- Undefined: entry 0 is an ordinary register like all others.

Test Plan:
- Reset/init (defaults): hold rst 3 cycles, release -> init_done=0 for 16 cycles then 1; read all 16 entries -> rd=0x0000, busy=0.
- Write/read: write wa=5 wd=0x00A5, next cycle ra1=5, ra2=5 -> one cycle later rd1=rd2=0x00A5.
- Bypass: entry 7 holds 0x1111; same cycle regwrite wa=7 wd=0x2222 with ra1=7 -> rd1=0x2222 next cycle; entry 7 then reads 0x2222.
- Scoreboard:
  - rsv rsv_addr=3, then ra2=3 -> busy2=1.
  - regwrite wa=3 -> busy2=0 the next read.
  - Same-cycle rsv+write to 3 -> busy2=1.
- Clear mid-operation:
  - Write 0xBEEF to entry 9, pulse clr_req -> init_done low 16 cycles, rd1 for ra1=9 returns 0 afterwards.
  - Assert rst at clear cycle 8 -> a full 16-cycle INIT restarts.
- With REGFILE_SB_ZERO_R0_EN: write wa=0 wd=0xFFFF with ra1=0 -> rd1=0x0000 (also on the bypass cycle); rsv rsv_addr=0 -> busy1=0.
